parent_link_arbiter: RTL and testbench

- Shares one 64-bit parent link among NUM_CORES decoder cores, each a core-plus-message-handler instance, inside one FPGA.
- Tx path: round-robin merge of per-core message streams onto parent_tx, with packet locking and source-ID stamping.
- Rx path: routes parent_rx words into per-core receive FIFOs by destination field; supports broadcast.
- Sits between the per-core message handlers and the physical parent link.

---
 rtl/parent_link_arbiter_pkg.sv | 19 +
 rtl/parent_link_arbiter_rr_arbiter.sv | 40 ++++
 rtl/parent_link_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_parent_link_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parent_link_arbiter_pkg.sv
// Shared defaults and tx FSM states for the parent link arbiter.
// Optional counters are built when PARENT_LINK_STATS_EN is defined.
package parent_link_arbiter_pkg;

  localparam int PLA_DATA_WIDTH  = 64;
  localparam int PLA_CORE_ID_LSB = 56;
  localparam int PLA_BCAST_BIT   = 63;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } tx_state_e;

  // Core index a+b folded back into 0..n-1 (a, b both < n).
  function automatic int wrap_idx(input int a, input int n);
    return (a >= n) ? a - n : a;
  endfunction

endpackage

// File: rtl/parent_link_arbiter_rr_arbiter.sv
// Round-robin grant with packet lock for the parent tx merge.
// Returns a one-hot grant and its index.
module parent_link_arbiter_rr_arbiter
  import parent_link_arbiter_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int IW        = 2
) (
  input  logic [NUM_CORES-1:0] i_req,
  input  logic [IW-1:0]        i_rr_ptr,
  input  logic                 i_lock,
  input  logic [IW-1:0]        i_lock_idx,
  output logic [NUM_CORES-1:0] o_gnt,
  output logic [IW-1:0]        o_idx
);

  logic [IW-1:0] w_k;

  // Locked: owner only. Else scan downward so the
  // nearest request at/after rr_ptr wins last.
  always_comb begin
    o_gnt = '0;
    o_idx = i_rr_ptr;
    w_k   = '0;
    if (i_lock) begin
      o_gnt[i_lock_idx] = 1'b1;
      o_idx = i_lock_idx;
    end else begin
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
        w_k = IW'(wrap_idx(int'(i_rr_ptr) + i, NUM_CORES));
        if (i_req[w_k]) begin
          o_gnt      = '0;
          o_gnt[w_k] = 1'b1;
          o_idx      = w_k;
        end
      end
    end
  end

endmodule

// File: rtl/parent_link_arbiter.sv
// Shares one parent link among NUM_CORES cores: rr tx merge, rx routing.
// Define PARENT_LINK_STATS_EN for drop_count and per-core word counters.
module parent_link_arbiter
  import parent_link_arbiter_pkg::*;
#(
  parameter int NUM_CORES     = 4,
  parameter int DATA_WIDTH    = PLA_DATA_WIDTH,
  parameter int RX_FIFO_DEPTH = 16,
  parameter int CORE_ID_LSB   = PLA_CORE_ID_LSB,
  parameter int BCAST_BIT     = PLA_BCAST_BIT
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_CORES*DATA_WIDTH-1:0] core_tx_data,
  input  logic [NUM_CORES-1:0]            core_tx_last,
  input  logic [NUM_CORES-1:0]            core_tx_valid,
  output logic [NUM_CORES-1:0]            core_tx_ready,
  output logic [DATA_WIDTH-1:0]           parent_tx_data,
  output logic                            parent_tx_valid,
  input  logic                            parent_tx_ready,
  input  logic [DATA_WIDTH-1:0]           parent_rx_data,
  input  logic                            parent_rx_valid,
  output logic                            parent_rx_ready,
  output logic [NUM_CORES*DATA_WIDTH-1:0] core_rx_data,
  output logic [NUM_CORES-1:0]            core_rx_valid,
  input  logic [NUM_CORES-1:0]            core_rx_ready,
  output logic [15:0]                     drop_count
);

  localparam int CID_W = $clog2(NUM_CORES);
  localparam int AW    = $clog2(RX_FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  tx_state_e             r_state;
  logic [CID_W-1:0]      r_rr_ptr;
  logic [CID_W-1:0]      r_lock_idx;
  logic                  r_tx_valid;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic [NUM_CORES-1:0]  w_gnt;
  logic [CID_W-1:0]      w_gnt_idx;
  logic [CID_W-1:0]      w_next_ptr;
  logic [DATA_WIDTH-1:0] w_sel;
  logic [DATA_WIDTH-1:0] w_stamped;
  logic                  w_out_free;
  logic                  w_xfer;
  logic                  w_last;

  parent_link_arbiter_rr_arbiter #(
    .NUM_CORES (NUM_CORES),
    .IW        (CID_W)
  ) u_rr (
    .i_req      (core_tx_valid),
    .i_rr_ptr   (r_rr_ptr),
    .i_lock     (r_state == ST_LOCKED),
    .i_lock_idx (r_lock_idx),
    .o_gnt      (w_gnt),
    .o_idx      (w_gnt_idx)
  );

  assign w_out_free = !r_tx_valid || parent_tx_ready;
  assign core_tx_ready = reset ?
    (w_gnt & {NUM_CORES{w_out_free}}) : '0;
  assign w_xfer = |(core_tx_valid & core_tx_ready);
  assign w_sel  = core_tx_data[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];
  assign w_last = core_tx_last[w_gnt_idx];
  assign w_next_ptr = (int'(w_gnt_idx) == NUM_CORES - 1) ?
    '0 : w_gnt_idx + CID_W'(1);
  assign parent_tx_data  = r_tx_data;
  assign parent_tx_valid = r_tx_valid;

  // Overwrite the core-ID field with the granted source.
  always_comb begin
    w_stamped = w_sel;
    w_stamped[CORE_ID_LSB +: CID_W] = w_gnt_idx;
  end

  // Tx FSM: packet lock, rr pointer and output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_lock_idx <= '0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      if (w_xfer) begin
        r_tx_valid <= 1'b1;
        r_tx_data  <= w_stamped;
        if (w_last) begin
          r_state  <= ST_IDLE;
          r_rr_ptr <= w_next_ptr;
        end else begin
          r_state    <= ST_LOCKED;
          r_lock_idx <= w_gnt_idx;
        end
      end else if (parent_tx_ready) begin
        r_tx_valid <= 1'b0;
      end
    end
  end

  logic [CID_W-1:0]     w_dest;
  logic                 w_bcast;
  logic                 w_dest_ok;
  logic                 w_rx_hs;
  logic [NUM_CORES-1:0] w_full;
  logic [NUM_CORES-1:0] w_push;
  logic [NUM_CORES-1:0] w_pop;

  assign w_dest    = parent_rx_data[CORE_ID_LSB +: CID_W];
  assign w_bcast   = parent_rx_data[BCAST_BIT];
  assign w_dest_ok = int'(w_dest) < NUM_CORES;
  assign parent_rx_ready = w_bcast ? ~|w_full :
    (w_dest_ok ? !w_full[w_dest] : 1'b1);
  assign w_rx_hs = parent_rx_valid && parent_rx_ready;
  assign w_pop   = core_rx_valid & core_rx_ready;

  // Select the FIFO(s) written by an rx handshake.
  always_comb begin
    w_push = '0;
    if (w_rx_hs) begin
      if (w_bcast) w_push = '1;
      else if (w_dest_ok) w_push[w_dest] = 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_rx
    logic [DATA_WIDTH-1:0] r_mem [RX_FIFO_DEPTH];
    logic [AW:0]           r_wp;
    logic [AW:0]           r_rp;

    assign w_full[gi] = (r_wp[AW] != r_rp[AW]) &&
      (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign core_rx_valid[gi] = r_wp != r_rp;
    assign core_rx_data[gi*DATA_WIDTH +: DATA_WIDTH] =
      r_mem[r_rp[AW-1:0]];

    // FIFO pointers; the extra MSB tells full from empty.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_wp <= '0;
        r_rp <= '0;
      end else begin
        if (w_push[gi]) r_wp <= r_wp + PTR_ONE;
        if (w_pop[gi])  r_rp <= r_rp + PTR_ONE;
      end
    end

    // FIFO storage, no reset needed.
    always_ff @(posedge clk) begin
      if (w_push[gi]) r_mem[r_wp[AW-1:0]] <= parent_rx_data;
    end
  end

`ifdef PARENT_LINK_STATS_EN
  logic [15:0] r_drop_cnt;
  logic [31:0] r_tx_word_cnt [NUM_CORES];
  logic [31:0] r_rx_word_cnt [NUM_CORES];
  logic        w_drop;

  assign w_drop = w_rx_hs && !w_bcast && !w_dest_ok;
  assign drop_count = r_drop_cnt;

  // Saturating drop counter and per-core word counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drop_cnt <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        r_tx_word_cnt[i] <= '0;
        r_rx_word_cnt[i] <= '0;
      end
    end else begin
      if (w_drop && r_drop_cnt != 16'hFFFF)
        r_drop_cnt <= r_drop_cnt + 16'd1;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (core_tx_valid[i] && core_tx_ready[i])
          r_tx_word_cnt[i] <= r_tx_word_cnt[i] + 32'd1;
        if (w_push[i])
          r_rx_word_cnt[i] <= r_rx_word_cnt[i] + 32'd1;
      end
    end
  end
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_parent_link_arbiter.sv
// Randomized bench for parent_link_arbiter with a queue-based model.
// Directed segments pin the model with literal expectations.
module tb_parent_link_arbiter;

  localparam int N     = 4;
  localparam int DW    = 64;
  localparam int LSB   = 56;
  localparam int CW    = 2;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  logic [N*DW-1:0] core_tx_data;
  logic [N-1:0]    core_tx_last, core_tx_valid, core_tx_ready;
  logic [DW-1:0]   parent_tx_data;
  logic            parent_tx_valid, parent_tx_ready;
  logic [DW-1:0]   parent_rx_data;
  logic            parent_rx_valid, parent_rx_ready;
  logic [N*DW-1:0] core_rx_data;
  logic [N-1:0]    core_rx_valid, core_rx_ready;
  logic [15:0]     drop_count;

  logic [3*DW-1:0] d3_ctx_data;
  logic [2:0]      d3_ctx_last, d3_ctx_valid, d3_ctx_ready;
  logic [DW-1:0]   d3_ptx_data;
  logic            d3_ptx_valid, d3_ptx_ready;
  logic [DW-1:0]   d3_prx_data;
  logic            d3_prx_valid, d3_prx_ready;
  logic [3*DW-1:0] d3_crx_data;
  logic [2:0]      d3_crx_valid, d3_crx_ready;
  logic [15:0]     d3_drop;

  always #5 clk = ~clk;

  parent_link_arbiter dut (
    .clk (clk), .reset (reset),
    .core_tx_data (core_tx_data), .core_tx_last (core_tx_last),
    .core_tx_valid (core_tx_valid), .core_tx_ready (core_tx_ready),
    .parent_tx_data (parent_tx_data), .parent_tx_valid (parent_tx_valid),
    .parent_tx_ready (parent_tx_ready),
    .parent_rx_data (parent_rx_data), .parent_rx_valid (parent_rx_valid),
    .parent_rx_ready (parent_rx_ready),
    .core_rx_data (core_rx_data), .core_rx_valid (core_rx_valid),
    .core_rx_ready (core_rx_ready), .drop_count (drop_count)
  );

  parent_link_arbiter #(.NUM_CORES(3)) dut3 (
    .clk (clk), .reset (reset),
    .core_tx_data (d3_ctx_data), .core_tx_last (d3_ctx_last),
    .core_tx_valid (d3_ctx_valid), .core_tx_ready (d3_ctx_ready),
    .parent_tx_data (d3_ptx_data), .parent_tx_valid (d3_ptx_valid),
    .parent_tx_ready (d3_ptx_ready),
    .parent_rx_data (d3_prx_data), .parent_rx_valid (d3_prx_valid),
    .parent_rx_ready (d3_prx_ready),
    .core_rx_data (d3_crx_data), .core_rx_valid (d3_crx_valid),
    .core_rx_ready (d3_crx_ready), .drop_count (d3_drop)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // stimulus queues: {last, data}
  logic [DW:0]   txq [N][$];
  logic [DW-1:0] rxq [$];
  logic [N-1:0]  tx_en, tx_hold;
  logic          rx_en, rx_hold;
  // model state
  logic [DW-1:0] sbq [N][$];
  logic [DW-1:0] mq  [N][$];
  logic [DW-1:0] txlog [$];
  int            m_ptr, m_owner, m_drop;
  logic          m_ov;
  logic [DW-1:0] m_od;
  // snapshots taken at the check point of each step
  logic [DW-1:0]   s_ptx_data;
  logic [N-1:0]    s_ctx_rdy, s_crx_v;
  logic            s_prx_rdy;
  logic [N*DW-1:0] s_crx_d;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < N; i++) begin
      core_tx_valid[i] = txq[i].size() > 0 && (tx_hold[i] || tx_en[i]);
      if (txq[i].size() > 0)
        {core_tx_last[i], core_tx_data[i*DW +: DW]} = txq[i][0];
      else
        {core_tx_last[i], core_tx_data[i*DW +: DW]} = '0;
    end
    parent_rx_valid = rxq.size() > 0 && (rx_hold || rx_en);
    parent_rx_data  = (rxq.size() > 0) ? rxq[0] : '0;
  endtask

  task automatic step();
    logic [N-1:0]  exp_rdy, exp_v, hs_tx;
    logic          ofree, xfer, exp_prx, bc, hs_rx;
    logic [DW-1:0] w;
    int            g, dst;
    apply_inputs();
    @(negedge clk);
    s_ptx_data = parent_tx_data;
    s_ctx_rdy  = core_tx_ready;
    s_prx_rdy  = parent_rx_ready;
    s_crx_v    = core_rx_valid;
    s_crx_d    = core_rx_data;
    // tx: who may move a word this cycle
    ofree = !m_ov || parent_tx_ready;
    g = -1;
    if (m_owner >= 0) g = m_owner;
    else
      for (int k = 0; k < N; k++)
        if (g < 0 && core_tx_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    exp_rdy = '0;
    if (g >= 0 && ofree) exp_rdy[g] = 1'b1;
    chk("core_tx_ready", 64'(core_tx_ready), 64'(exp_rdy));
    chk("ptx_valid", 64'(parent_tx_valid), 64'(m_ov));
    if (m_ov) chk("ptx_data", parent_tx_data, m_od);
    if (parent_tx_valid && parent_tx_ready) begin
      w = parent_tx_data;
      txlog.push_back(w);
      dst = int'(w[LSB +: CW]);
      if (sbq[dst].size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL tx_spurious: got %h want none", w);
      end else begin
        chk("tx_stream", w, sbq[dst].pop_front());
      end
    end
    xfer = g >= 0 && ofree && core_tx_valid[g];
    if (xfer) begin
      w = core_tx_data[g*DW +: DW];
      w[LSB +: CW] = CW'(g);
      m_ov = 1'b1;
      m_od = w;
      if (core_tx_last[g]) begin
        m_owner = -1;
        m_ptr = (g + 1) % N;
      end else begin
        m_owner = g;
      end
    end else if (parent_tx_ready) begin
      m_ov = 1'b0;
    end
    // rx
    exp_v = '0;
    for (int i = 0; i < N; i++) begin
      exp_v[i] = mq[i].size() > 0;
      if (exp_v[i]) chk("crx_data", core_rx_data[i*DW +: DW], mq[i][0]);
    end
    chk("crx_valid", 64'(core_rx_valid), 64'(exp_v));
    dst = int'(parent_rx_data[LSB +: CW]);
    bc  = parent_rx_data[63];
    exp_prx = 1'b1;
    if (bc) begin
      for (int i = 0; i < N; i++) if (mq[i].size() == DEPTH) exp_prx = 1'b0;
    end else if (dst < N) begin
      exp_prx = mq[dst].size() < DEPTH;
    end
    chk("prx_ready", 64'(parent_rx_ready), 64'(exp_prx));
    chk("drop_count", 64'(drop_count), 64'(m_drop));
    for (int i = 0; i < N; i++)
      if (mq[i].size() > 0 && core_rx_ready[i]) void'(mq[i].pop_front());
    if (parent_rx_valid && exp_prx) begin
      if (bc) for (int i = 0; i < N; i++) mq[i].push_back(parent_rx_data);
      else if (dst < N) mq[dst].push_back(parent_rx_data);
      else m_drop++;
    end
    // driver bookkeeping
    hs_tx = core_tx_valid & core_tx_ready;
    hs_rx = parent_rx_valid && parent_rx_ready;
    tx_hold = core_tx_valid & ~core_tx_ready;
    rx_hold = parent_rx_valid && !parent_rx_ready;
    for (int i = 0; i < N; i++)
      if (hs_tx[i]) begin
        w = txq[i][0][DW-1:0];
        w[LSB +: CW] = CW'(i);
        sbq[i].push_back(w);
      end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (hs_tx[i]) void'(txq[i].pop_front());
    if (hs_rx) void'(rxq.pop_front());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: sim time expired, want finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] exp2 [5];
    logic [DW-1:0] exp3 [3];
    logic [DW-1:0] w;
    int len;
    logic [15:0] d3_exp_drop;
    core_tx_data = '0; core_tx_last = '0; core_tx_valid = '0;
    parent_tx_ready = 1'b1; parent_rx_data = '0; parent_rx_valid = 1'b0;
    core_rx_ready = '1;
    d3_ctx_data = '0; d3_ctx_last = '0; d3_ctx_valid = '0;
    d3_ptx_ready = 1'b1; d3_prx_data = '0; d3_prx_valid = 1'b0;
    d3_crx_ready = '0;
    tx_en = '1; tx_hold = '0; rx_en = 1'b1; rx_hold = 1'b0;
    m_ptr = 0; m_owner = -1; m_drop = 0; m_ov = 1'b0; m_od = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ptx_valid", 64'(parent_tx_valid), 64'd0);
    chk("rst_ptx_data", parent_tx_data, 64'd0);
    chk("rst_ctx_ready", 64'(core_tx_ready), 64'd0);
    chk("rst_crx_valid", 64'(core_rx_valid), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // three single-word packets in rr order
    txq[0].push_back({1'b1, 64'h11});
    txq[1].push_back({1'b1, 64'h22});
    txq[2].push_back({1'b1, 64'h33});
    repeat (6) step();
    chk("t1_count", 64'(txlog.size()), 64'd3);
    if (txlog.size() == 3) begin
      chk("t1_w0", txlog[0], 64'h0000_0000_0000_0011);
      chk("t1_w1", txlog[1], 64'h0100_0000_0000_0022);
      chk("t1_w2", txlog[2], 64'h0200_0000_0000_0033);
    end
    chk("t1_rr_ptr", 64'(dut.r_rr_ptr), 64'd3);
    txlog.delete();

    // core 1 packet stays contiguous while core 0 keeps asking
    txq[0].push_back({1'b1, 64'hA0});
    txq[0].push_back({1'b1, 64'hA1});
    txq[1].push_back({1'b0, 64'hB0});
    txq[1].push_back({1'b0, 64'hB1});
    txq[1].push_back({1'b1, 64'hB2});
    exp2 = '{64'hA0, 64'h0100_0000_0000_00B0, 64'h0100_0000_0000_00B1,
             64'h0100_0000_0000_00B2, 64'hA1};
    repeat (9) step();
    chk("t2_count", 64'(txlog.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      if (i < txlog.size()) chk("t2_order", txlog[i], exp2[i]);
    txlog.delete();

    // output stall holds data, no loss or duplicate
    txq[2].push_back({1'b1, 64'h44});
    txq[2].push_back({1'b1, 64'h55});
    txq[2].push_back({1'b1, 64'h66});
    step();
    parent_tx_ready = 1'b0;
    repeat (5) begin
      step();
      chk("t3_hold_data", s_ptx_data, 64'h0200_0000_0000_0044);
      chk("t3_hold_rdy", 64'(s_ctx_rdy), 64'd0);
    end
    parent_tx_ready = 1'b1;
    repeat (5) step();
    exp3 = '{64'h0200_0000_0000_0044, 64'h0200_0000_0000_0055,
             64'h0200_0000_0000_0066};
    chk("t3_count", 64'(txlog.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      if (i < txlog.size()) chk("t3_order", txlog[i], exp3[i]);
    txlog.delete();

    // rx FIFO 3 fills, one pop reopens it a cycle later
    core_rx_ready = 4'b0111;
    for (int k = 0; k < 17; k++) rxq.push_back(64'h0300_0000_0000_0000 | 64'(k));
    repeat (16) step();
    step();
    chk("t4_full_rdy", 64'(s_prx_rdy), 64'd0);
    core_rx_ready[3] = 1'b1;
    step();
    chk("t4_pop_rdy", 64'(s_prx_rdy), 64'd0);
    core_rx_ready[3] = 1'b0;
    step();
    chk("t4_reopen_rdy", 64'(s_prx_rdy), 64'd1);
    core_rx_ready = '1;
    repeat (20) step();

    // broadcast reaches every core
    core_rx_ready = '0;
    rxq.push_back(64'h8000_0000_0000_00AA);
    step();
    step();
    chk("t5_bc_valid", 64'(s_crx_v), 64'hF);
    for (int i = 0; i < N; i++)
      chk("t5_bc_data", s_crx_d[i*DW +: DW], 64'h8000_0000_0000_00AA);
    core_rx_ready = '1;
    step();
    // broadcast blocked by a full FIFO 2
    core_rx_ready = 4'b1011;
    for (int k = 0; k < 16; k++) rxq.push_back(64'h0200_0000_0000_0000 | 64'(k));
    rxq.push_back(64'h8000_0000_0000_00BB);
    repeat (16) step();
    repeat (3) begin
      step();
      chk("t5_bc_block", 64'(s_prx_rdy), 64'd0);
    end
    core_rx_ready[2] = 1'b1;
    step();
    chk("t5_pop_rdy", 64'(s_prx_rdy), 64'd0);
    core_rx_ready[2] = 1'b0;
    step();
    chk("t5_bc_go", 64'(s_prx_rdy), 64'd1);
    core_rx_ready = '1;
    repeat (20) step();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (txq[i].size() < 6 && $urandom_range(3) == 0) begin
          len = 1 + $urandom_range(2);
          for (int j = 0; j < len; j++)
            txq[i].push_back({j == len - 1, $urandom, $urandom});
        end
      end
      if (rxq.size() < 4 && $urandom_range(2) == 0) begin
        w = {$urandom, $urandom};
        w[63] = $urandom_range(7) == 0;
        rxq.push_back(w);
      end
      tx_en = 4'($urandom);
      rx_en = $urandom_range(3) != 0;
      parent_tx_ready = $urandom_range(3) != 0;
      core_rx_ready = 4'($urandom);
      step();
    end
    tx_en = '1; rx_en = 1'b1; parent_tx_ready = 1'b1; core_rx_ready = '1;
    repeat (60) step();
    for (int i = 0; i < N; i++) begin
      chk("drain_txq", 64'(txq[i].size()), 64'd0);
      chk("drain_sb", 64'(sbq[i].size()), 64'd0);
    end

    // 3-core build: dest 3 unicast is dropped
`ifdef PARENT_LINK_STATS_EN
    d3_exp_drop = 16'd1;
`else
    d3_exp_drop = 16'd0;
`endif
    d3_prx_data = 64'h0300_0000_0000_0001;
    d3_prx_valid = 1'b1;
    @(negedge clk);
    chk("d3_drop_rdy", 64'(d3_prx_ready), 64'd1);
    @(posedge clk);
    #1;
    d3_prx_data = 64'h0200_0000_0000_0077;
    @(negedge clk);
    chk("d3_uni_rdy", 64'(d3_prx_ready), 64'd1);
    @(posedge clk);
    #1;
    d3_prx_valid = 1'b0;
    @(negedge clk);
    chk("d3_drop_count", 64'(d3_drop), 64'(d3_exp_drop));
    chk("d3_crx_valid", 64'(d3_crx_valid), 64'h4);
    chk("d3_crx_data", d3_crx_data[2*DW +: DW], 64'h0200_0000_0000_0077);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
